// File: rtl/dlx_mul_pkg.sv
// Shared types and sizing for the DLX iterative multiply unit.
package dlx_mul_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned WIDTH_DEF = 32;
  localparam int unsigned DIGIT_DEF = 8;

  function automatic int unsigned iter_of(input int unsigned width, input int unsigned digit);
    return width / digit;
  endfunction

  // A single-iteration configuration still needs a one-bit counter.
  function automatic int unsigned cnt_width(input int unsigned iter);
    return (iter > 1) ? $clog2(iter) : 1;
  endfunction

  localparam int unsigned ITER_DEF  = iter_of(WIDTH_DEF, DIGIT_DEF);
  localparam int unsigned CNT_W_DEF = cnt_width(ITER_DEF);

endpackage

// File: rtl/dlx_mul_unit_if.sv
// Request/response bundle between ID-stage control and the multiply unit.
interface dlx_mul_unit_if
  import dlx_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);
  logic             start;
  logic             mul_unsigned;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [4:0]       rd_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic             fp_wr_en;
  logic [4:0]       rd_out;
  logic [WIDTH-1:0] result_lo;
  logic [WIDTH-1:0] result_hi;

  modport master (
    output start, mul_unsigned, op_a, op_b, rd_in, flush,
    input  busy, done, fp_wr_en, rd_out, result_lo, result_hi
  );

  modport slave (
    input  start, mul_unsigned, op_a, op_b, rd_in, flush,
    output busy, done, fp_wr_en, rd_out, result_lo, result_hi
  );
endinterface

// File: rtl/mul_digit_pp.sv
// Unsigned WIDTH x DIGIT partial product for one multiplier slice.
module mul_digit_pp
  import dlx_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIGIT = DIGIT_DEF
) (
  input  logic [WIDTH-1:0]       mcand,
  input  logic [DIGIT-1:0]       digit,
  output logic [WIDTH+DIGIT-1:0] pp
);
  assign pp = (WIDTH+DIGIT)'(mcand) * (WIDTH+DIGIT)'(digit);
endmodule

// File: rtl/dlx_mul_unit.sv
// Multi-cycle MULT/MULTU unit: sign-magnitude operands, DIGIT bits per cycle,
// sign fixup on the final accumulate edge, one-cycle done/write pulse.
module dlx_mul_unit
  import dlx_mul_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned DIGIT = DIGIT_DEF
) (
  input  logic           clk,
  input  logic           reset,
  dlx_mul_unit_if.slave  bus
);
  localparam int unsigned ITER  = iter_of(WIDTH, DIGIT);
  localparam int unsigned CNT_W = cnt_width(ITER);
  localparam int unsigned PW    = 2 * WIDTH;

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic [WIDTH-1:0]       mcand;
  logic [WIDTH-1:0]       mplier;
  logic [PW-1:0]          acc;
  logic                   neg;
  logic [4:0]             rd_q;
  logic [WIDTH-1:0]       res_lo;
  logic [WIDTH-1:0]       res_hi;
  logic                   busy_q;
  logic                   done_q;

  logic [WIDTH+DIGIT-1:0] pp;
  logic [PW-1:0]          acc_next;
  logic [PW-1:0]          prod_final;
  logic [WIDTH-1:0]       mag_a;
  logic [WIDTH-1:0]       mag_b;
  logic                   neg_in;
  logic                   last;
  logic                   accept;

  mul_digit_pp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_pp (
    .mcand (mcand),
    .digit (mplier[DIGIT-1:0]),
    .pp    (pp)
  );

  always_comb begin
    mag_a      = (!bus.mul_unsigned && bus.op_a[WIDTH-1]) ? -bus.op_a : bus.op_a;
    mag_b      = (!bus.mul_unsigned && bus.op_b[WIDTH-1]) ? -bus.op_b : bus.op_b;
    neg_in     = !bus.mul_unsigned && (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
    acc_next   = acc + (PW'(pp) << (DIGIT * cnt));
    prod_final = neg ? -acc_next : acc_next;
    last       = (cnt == CNT_W'(ITER - 1));
    // flush outranks a back-to-back start in DONE; start during RUN is dropped
    accept     = bus.start && ((state == IDLE) || (state == DONE && !bus.flush));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      neg    <= 1'b0;
      rd_q   <= '0;
      res_lo <= '0;
      res_hi <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        RUN: begin
          if (bus.flush) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            acc    <= acc_next;
            mplier <= mplier >> DIGIT;
            cnt    <= cnt + 1'b1;
            if (last) begin
              {res_hi, res_lo} <= prod_final;
              state  <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (accept) begin
        mcand  <= mag_a;
        mplier <= mag_b;
        neg    <= neg_in;
        rd_q   <= bus.rd_in;
        acc    <= '0;
        cnt    <= '0;
        state  <= RUN;
        busy_q <= 1'b1;
      end
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.fp_wr_en  = done_q;
  assign bus.rd_out    = rd_q;
  assign bus.result_lo = res_lo;
  assign bus.result_hi = res_hi;

endmodule

// File: tb/tb_dlx_mul_unit.sv
// Self-checking bench for dlx_mul_unit against a 64-bit arithmetic reference.
module tb_dlx_mul_unit;
  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  dlx_mul_unit_if #(.WIDTH(32)) ifc ();

  dlx_mul_unit #(.WIDTH(32), .DIGIT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests run %0d", n_tests);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b, input logic u);
    longint     sa, sb;
    logic [63:0] ua, ub;
    if (u) begin
      ua = {32'b0, a};
      ub = {32'b0, b};
      return ua * ub;
    end
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  task automatic idle_inputs;
    ifc.start        = 1'b0;
    ifc.flush        = 1'b0;
    ifc.mul_unsigned = 1'b0;
    ifc.op_a         = '0;
    ifc.op_b         = '0;
    ifc.rd_in        = '0;
  endtask

  task automatic drive_start(input logic [31:0] a, input logic [31:0] b, input logic u, input logic [4:0] rd);
    ifc.start        = 1'b1;
    ifc.op_a         = a;
    ifc.op_b         = b;
    ifc.mul_unsigned = u;
    ifc.rd_in        = rd;
  endtask

  // Called one negedge after acceptance (k=1); returns at the done negedge or on budget.
  task automatic wait_done(input int k0, output int k, output int bc);
    k  = k0;
    bc = 0;
    while (!ifc.done && k < 16) begin
      if (ifc.busy) bc++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic u, input logic [4:0] rd);
    logic [63:0] exp;
    int k, bc;
    exp = ref_prod(a, b, u);
    @(negedge clk);
    drive_start(a, b, u, rd);
    @(negedge clk);
    ifc.start        = 1'b0;
    ifc.op_a         = $urandom;
    ifc.op_b         = $urandom;
    ifc.mul_unsigned = 1'($urandom);
    ifc.rd_in        = 5'($urandom);
    wait_done(1, k, bc);
    n_tests++;
    if (k !== 5) begin
      n_fail++;
      $display("FAIL %s latency: got done at cycle %0d, want 5", name, k);
    end
    n_tests++;
    if (bc !== 4) begin
      n_fail++;
      $display("FAIL %s busy_cycles: got %0d, want 4", name, bc);
    end
    n_tests++;
    if ({ifc.result_hi, ifc.result_lo} !== exp) begin
      n_fail++;
      $display("FAIL %s product: a=%h b=%h u=%0d got %h_%h want %h", name, a, b, u,
               ifc.result_hi, ifc.result_lo, exp);
    end
    n_tests++;
    if ({ifc.rd_out, ifc.fp_wr_en} !== {rd, 1'b1}) begin
      n_fail++;
      $display("FAIL %s rd/wr_en: got rd=%0d we=%b want rd=%0d we=1", name, ifc.rd_out, ifc.fp_wr_en, rd);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    idle_inputs();
    repeat (2) @(negedge clk);
    n_tests++;
    if ({ifc.busy, ifc.done, ifc.fp_wr_en, ifc.rd_out, ifc.result_hi, ifc.result_lo} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b we=%b rd=%0d hi=%h lo=%h want all 0",
               ifc.busy, ifc.done, ifc.fp_wr_en, ifc.rd_out, ifc.result_hi, ifc.result_lo);
    end
    reset = 1'b0;
  endtask

  task automatic test_directed;
    run_op("mult_6x7", 32'd6, 32'd7, 1'b0, 5'd3);
    n_tests++;
    if ({ifc.result_hi, ifc.result_lo} !== 64'h0000_0000_0000_002A) begin
      n_fail++;
      $display("FAIL mult_6x7_const: got %h_%h want 00000000_0000002a", ifc.result_hi, ifc.result_lo);
    end
    @(negedge clk);
    n_tests++;
    if ({ifc.done, ifc.fp_wr_en, ifc.busy} !== 3'b000 || ifc.result_lo !== 32'h2A) begin
      n_fail++;
      $display("FAIL done_one_cycle: done=%b we=%b busy=%b lo=%h want 0 0 0 0000002a",
               ifc.done, ifc.fp_wr_en, ifc.busy, ifc.result_lo);
    end
    run_op("mult_neg3x5",  32'hFFFF_FFFD, 32'd5, 1'b0, 5'd7);
    n_tests++;
    if ({ifc.result_hi, ifc.result_lo} !== 64'hFFFF_FFFF_FFFF_FFF1) begin
      n_fail++;
      $display("FAIL mult_neg3x5_const: got %h_%h want ffffffff_fffffff1", ifc.result_hi, ifc.result_lo);
    end
    run_op("multu_fffd_x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 5'd8);
    n_tests++;
    if ({ifc.result_hi, ifc.result_lo} !== 64'h0000_0004_FFFF_FFF1) begin
      n_fail++;
      $display("FAIL multu_fffd_x5_const: got %h_%h want 00000004_fffffff1", ifc.result_hi, ifc.result_lo);
    end
    run_op("multu_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5'd31);
    run_op("mult_minneg", 32'h8000_0000, 32'h8000_0000, 1'b0, 5'd1);
    n_tests++;
    if ({ifc.result_hi, ifc.result_lo} !== 64'h4000_0000_0000_0000) begin
      n_fail++;
      $display("FAIL mult_minneg_const: got %h_%h want 40000000_00000000", ifc.result_hi, ifc.result_lo);
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0:       a = 32'h8000_0000;
        1:       a = 32'hFFFF_FFFF;
        2:       a = 32'd0;
        default: a = $urandom;
      endcase
      b = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      run_op("random", a, b, 1'($urandom), 5'($urandom));
    end
  endtask

  task automatic test_back_to_back;
    int k, bc;
    @(negedge clk);
    drive_start(32'd2, 32'd3, 1'b0, 5'd4);
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    drive_start(32'd9, 32'd9, 1'b0, 5'd9);
    @(negedge clk);
    ifc.start = 1'b0;
    wait_done(3, k, bc);
    n_tests++;
    if (k !== 5 || {ifc.result_hi, ifc.result_lo} !== 64'd6 || ifc.rd_out !== 5'd4) begin
      n_fail++;
      $display("FAIL start_ignored_in_run: k=%0d got %h_%h rd=%0d want k=5 product 6 rd=4",
               k, ifc.result_hi, ifc.result_lo, ifc.rd_out);
    end
    drive_start(32'd9, 32'd9, 1'b0, 5'd9);
    @(negedge clk);
    ifc.start = 1'b0;
    n_tests++;
    if ({ifc.busy, ifc.done} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_accept: busy=%b done=%b want busy=1 done=0", ifc.busy, ifc.done);
    end
    wait_done(1, k, bc);
    n_tests++;
    if (k !== 5 || {ifc.result_hi, ifc.result_lo} !== 64'd81 || ifc.rd_out !== 5'd9) begin
      n_fail++;
      $display("FAIL b2b_result: k=%0d got %h_%h rd=%0d want k=5 product 81 rd=9",
               k, ifc.result_hi, ifc.result_lo, ifc.rd_out);
    end
  endtask

  task automatic test_flush;
    int seen;
    @(negedge clk);
    drive_start(32'd10, 32'd10, 1'b0, 5'd2);
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ifc.flush = 1'b1;
    @(negedge clk);
    ifc.flush = 1'b0;
    n_tests++;
    if ({ifc.busy, ifc.done, ifc.fp_wr_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_run: busy=%b done=%b we=%b want 0 0 0", ifc.busy, ifc.done, ifc.fp_wr_en);
    end
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifc.done || ifc.busy) seen++;
    end
    n_tests++;
    if (seen !== 0 || {ifc.result_hi, ifc.result_lo} !== 64'd81) begin
      n_fail++;
      $display("FAIL flush_retain: activity=%0d got %h_%h want 0 activity, product 81",
               seen, ifc.result_hi, ifc.result_lo);
    end
    run_op("pre_flush_done", 32'd2, 32'd2, 1'b1, 5'd5);
    ifc.flush = 1'b1;
    drive_start(32'd5, 32'd5, 1'b0, 5'd6);
    @(negedge clk);
    ifc.flush = 1'b0;
    ifc.start = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (ifc.done || ifc.busy) seen++;
      @(negedge clk);
    end
    n_tests++;
    if (seen !== 0 || {ifc.result_hi, ifc.result_lo} !== 64'd4) begin
      n_fail++;
      $display("FAIL flush_beats_start: activity=%0d got %h_%h want 0 activity, product 4",
               seen, ifc.result_hi, ifc.result_lo);
    end
  endtask

  task automatic test_reset_mid_run;
    int seen;
    @(negedge clk);
    drive_start(32'd7, 32'd7, 1'b0, 5'd12);
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    n_tests++;
    if ({ifc.busy, ifc.done, ifc.fp_wr_en, ifc.rd_out, ifc.result_hi, ifc.result_lo} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b done=%b rd=%0d hi=%h lo=%h want all 0",
               ifc.busy, ifc.done, ifc.rd_out, ifc.result_hi, ifc.result_lo);
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (ifc.done || ifc.busy) seen++;
    end
    n_tests++;
    if (seen !== 0 || {ifc.result_hi, ifc.result_lo} !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_no_done: activity=%0d got %h_%h want none, product 0",
               seen, ifc.result_hi, ifc.result_lo);
    end
    run_op("after_reset", 32'hFFFF_FFF9, 32'd7, 1'b0, 5'd12);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dlx_mul_unit.md
Name: dlx_mul_unit

Overview:
Multi-cycle integer multiply execution unit for the DLX pipeline. It accepts the MULT/MULTU request that the ID-stage control issues (enable, signed/unsigned select, operands, FP destination tag). It computes the product iteratively, one DIGIT-bit slice of the multiplier per cycle, and returns a one-cycle done/write pulse with the 64-bit product and destination tag to the FP register file. While an operation is in flight it holds busy so the issuing control keeps the pipeline stalled.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH.
DIGIT, 8, multiplier bits consumed per cycle; must divide WIDTH.
ITER, WIDTH/DIGIT (4), accumulate cycles per operation (derived, not overridable).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high reset.
start  in  1  request pulse (enableMult qualified by control); sampled only when accepting.
mul_unsigned  in  1  1 = MULTU, 0 = MULT (signed, two's complement); mirrors mulSelect.
op_a  in  WIDTH  multiplicand.
op_b  in  WIDTH  multiplier.
rd_in  in  5  FP destination register.
flush  in  1  synchronous abort; kills any in-flight operation.
busy  out  1  operation in progress (RUN state).
done  out  1  one-cycle pulse: result valid.
fp_wr_en  out  1  FP register write enable; equal to done.
rd_out  out  5  latched destination tag; valid while done.
result_lo  out  WIDTH  product bits [WIDTH-1:0]; held until next accepted start.
result_hi  out  WIDTH  product bits [2*WIDTH-1:WIDTH]; held likewise.

Behaviour:
- Reset (async, any state): state=IDLE; busy=done=fp_wr_en=0; rd_out=0; result_lo=result_hi=0; internal counter, accumulator and operand registers =0. Reset during RUN discards the operation; no done pulse is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE: if start=1 at an edge: latch |op_a|, |op_b| (unsigned magnitudes when mul_unsigned=0, raw values when 1), neg = ~mul_unsigned & (op_a[MSB]^op_b[MSB]), rd_in; clear accumulator; cnt=0; go RUN.
- Magnitude of the most-negative value (0x80000000) is 2^31 as an unsigned WIDTH-bit quantity. No overflow or special case.
- RUN, every edge: acc += (mcand * mplier[DIGIT-1:0]) << (DIGIT*cnt); mplier >>= DIGIT; cnt++. acc is 2*WIDTH bits and the sum never overflows.
- RUN, edge where cnt==ITER-1: result_{hi,lo} = neg ? -(acc_next) : acc_next (2*WIDTH two's-complement negate). Go DONE.
- Latency: start accepted at edge E0; done high in the cycle after edge E0+ITER (E0+4 for default). busy is high from E0 through E0+ITER.
- DONE (exactly one cycle): done=fp_wr_en=1, rd_out valid.
  - If start=1, accept the new request as in IDLE and go RUN (back-to-back, no bubble).
  - Otherwise go IDLE.
- start while in RUN is ignored: not queued, and the in-flight operation is unaffected.
- flush=1 at an edge in RUN or DONE: go IDLE, done/fp_wr_en low next cycle. result_* keep their last completed values; start in the same cycle is ignored. flush takes priority over start.
- result_lo/result_hi change only on the final RUN edge. They are stable at all other times, including IDLE, and read-back after done is legal.
- mul_unsigned affects only result_hi and the sign fixup. result_lo is identical for MULT and MULTU on the same bit patterns.

Decomposition:
- Shared package dlx_mul_pkg:
  - state enum {IDLE, RUN, DONE}.
  - WIDTH/DIGIT defaults.
  - derived ITER and counter width $clog2(ITER).
- One sub-module, mul_digit_pp: combinational WIDTH x DIGIT unsigned partial product producing WIDTH+DIGIT bits. Instantiated once in the RUN datapath.
- FSM, shift/accumulate and sign fixup stay in dlx_mul_unit.

Test Plan:
1. MULT 6 x 7, rd_in=3 -> busy for 4 cycles, then done one cycle: lo=0x0000002A, hi=0, rd_out=3, fp_wr_en=1.
2. MULT 0xFFFFFFFD(-3) x 5 -> lo=0xFFFFFFF1, hi=0xFFFFFFFF. Same operands with MULTU -> lo=0xFFFFFFF1, hi=0x00000004.
3. MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT 0x80000000 x 0x80000000 -> hi=0x40000000, lo=0.
4. Start 2 x 3, pulse start (9 x 9) at cycle 2 of RUN -> only the result 6 is returned. Then start 9 x 9 in the DONE cycle -> accepted with no bubble, and 81 is returned 4 cycles later.
5. Start 10 x 10, assert flush in the 3rd RUN cycle -> no done pulse, state IDLE, result_* retain the prior value (81).
6. Assert reset mid-RUN -> all outputs 0 immediately (async), no done afterward. A new start after reset release completes normally.
